// File: rtl/axi_vga_fetch_sched.sv
// ---------------------------------------------------------------------------
// axi_vga_fetch_sched
//   Read-request scheduler for the VGA frame-buffer fetch path. Once per frame
//   it walks [frame_base, frame_base+frame_size) and issues AXI4 INCR AR bursts.
//   Each burst is cut at the configured length, the end of the frame and 4 KiB
//   address boundaries. An AR is raised only when the pixel FIFO has enough
//   unreserved credit for the whole burst and fewer than MaxOutstanding bursts
//   are still waiting for their R last.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            fetch enable; dropping it ends the frame after any
//                       pending AR handshake
//   frame_base_i        frame start address (bytes), latched on frame start
//   frame_size_i        frame size in bytes, latched on frame start
//   burst_len_i         maximum AXI len (beats-1), latched on frame start
//   frame_start_i       1-cycle pulse: begin the next frame (ignored when busy)
//   fifo_free_i         free entries in the pixel FIFO (beats)
//   ar_addr_o/len_o     AR payload
//   ar_valid_o/ready_i  AR handshake
//   r_beat_i, r_last_i  R handshake this cycle, and its last flag
//   busy_o              frame in progress or bursts outstanding (registered)
//   frame_done_o        1-cycle pulse once the last burst has fully returned
//
// Handshake: ar_valid_o follows strict valid/ready rules. Once raised it stays
// high with ar_addr_o/ar_len_o unchanged until the cycle where ar_ready_i is
// sampled high; credit is checked only when raising, never while holding.
//
// Debug: state_o exposes the FSM state (0 IDLE, 1 ISSUE, 2 DRAIN).
// ---------------------------------------------------------------------------
module axi_vga_fetch_sched #(
    parameter int AddrWidth      = 48,
    parameter int DataWidth      = 64,
    parameter int SizeWidth      = 32,
    parameter int FifoDepth      = 256,
    parameter int MaxOutstanding = 4,
    parameter int CntW           = $clog2(FifoDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [AddrWidth-1:0] frame_base_i,
    input  logic [SizeWidth-1:0] frame_size_i,
    input  logic [7:0]           burst_len_i,
    input  logic                 frame_start_i,
    input  logic [CntW-1:0]      fifo_free_i,
    output logic [AddrWidth-1:0] ar_addr_o,
    output logic [7:0]           ar_len_o,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    input  logic                 r_beat_i,
    input  logic                 r_last_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [1:0]           state_o
);

    localparam int BytesPerBeat = DataWidth / 8;
    localparam int BeatShift    = $clog2(BytesPerBeat);
    localparam int OutW         = $clog2(MaxOutstanding + 1);
    localparam int BW           = 13;              // holds up to 4096 beats
    localparam int RsvW         = CntW + 1;
    localparam int CrW          = CntW + BW + 2;   // signed credit arithmetic

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [SizeWidth-1:0] beats_rem_q, beats_rem_d;
    logic [7:0]           len_max_q, len_max_d;
    logic [7:0]           ar_len_q, ar_len_d;
    logic                 ar_valid_q, ar_valid_d;
    logic [RsvW-1:0]      reserved_q, reserved_d;
    logic [OutW-1:0]      outst_q, outst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [BW-1:0]        len_beats, page_beats, cap_beats, beats, hs_beats;
    logic signed [CrW-1:0] credit;
    logic                 can_issue;
    logic                 ar_hs;

    // Beats left before the next 4 KiB boundary; addr_q is always beat aligned.
    assign len_beats  = BW'(len_max_q) + BW'(1);
    assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> BeatShift;
    assign cap_beats  = (len_beats < page_beats) ? len_beats : page_beats;
    assign beats      = (beats_rem_q < SizeWidth'(cap_beats)) ? beats_rem_q[BW-1:0] : cap_beats;

    // reserved can exceed fifo_free_i if the FIFO shrinks; negative credit blocks.
    assign credit    = $signed(CrW'(fifo_free_i)) - $signed(CrW'(reserved_q));
    assign can_issue = (credit >= $signed(CrW'(beats))) && (outst_q < OutW'(MaxOutstanding));

    assign ar_hs    = ar_valid_q & ar_ready_i;
    assign hs_beats = BW'(ar_len_q) + BW'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beats_rem_d = beats_rem_q;
        len_max_d   = len_max_q;
        ar_len_d    = ar_len_q;
        ar_valid_d  = ar_valid_q;
        done_d      = 1'b0;

        // AR handshake and R beat in the same cycle net out.
        reserved_d = reserved_q + (ar_hs ? RsvW'(hs_beats) : RsvW'(0)) - RsvW'(r_beat_i);
        outst_d    = outst_q + OutW'(ar_hs) - OutW'(r_beat_i & r_last_i);

        case (state_q)
            ST_IDLE: begin
                if (frame_start_i && enable_i) begin
                    addr_d      = frame_base_i & ~AddrWidth'(BytesPerBeat - 1);
                    beats_rem_d = SizeWidth'(({1'b0, frame_size_i} +
                                  (SizeWidth + 1)'(BytesPerBeat - 1)) >> BeatShift);
                    len_max_d   = burst_len_i;
                    state_d     = (frame_size_i == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ar_valid_q) begin
                    if (ar_ready_i) begin
                        ar_valid_d  = 1'b0;
                        addr_d      = addr_q + (AddrWidth'(hs_beats) << BeatShift);
                        beats_rem_d = beats_rem_q - SizeWidth'(hs_beats);
                        if ((beats_rem_d == '0) || !enable_i) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end else if (!enable_i) begin
                    state_d = ST_DRAIN;
                end else if (can_issue) begin
                    ar_valid_d = 1'b1;
                    ar_len_d   = 8'(beats - BW'(1));
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || (outst_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beats_rem_q <= '0;
            len_max_q   <= '0;
            ar_len_q    <= '0;
            ar_valid_q  <= 1'b0;
            reserved_q  <= '0;
            outst_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beats_rem_q <= beats_rem_d;
            len_max_q   <= len_max_d;
            ar_len_q    <= ar_len_d;
            ar_valid_q  <= ar_valid_d;
            reserved_q  <= reserved_d;
            outst_q     <= outst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ar_addr_o    = addr_q;
    assign ar_len_o     = ar_len_q;
    assign ar_valid_o   = ar_valid_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_axi_vga_fetch_sched.sv
// Bench for axi_vga_fetch_sched: table of whole-frame vectors plus directed
// sequences for credit, outstanding limit, enable drop, empty frame, ignored
// frame_start and mid-frame reset.
module tb_axi_vga_fetch_sched;

    localparam int AW = 48;
    localparam int SW = 32;
    localparam int CW = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, enable_i, frame_start_i, ar_ready_i, r_beat_i, r_last_i;
    logic [AW-1:0] frame_base_i, ar_addr_o;
    logic [SW-1:0] frame_size_i;
    logic [7:0]    burst_len_i, ar_len_o;
    logic [CW-1:0] fifo_free_i;
    logic          ar_valid_o, busy_o, frame_done_o;
    logic [1:0]    state_o;

    axi_vga_fetch_sched dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .frame_base_i (frame_base_i),
        .frame_size_i (frame_size_i),
        .burst_len_i  (burst_len_i),
        .frame_start_i(frame_start_i),
        .fifo_free_i  (fifo_free_i),
        .ar_addr_o    (ar_addr_o),
        .ar_len_o     (ar_len_o),
        .ar_valid_o   (ar_valid_o),
        .ar_ready_i   (ar_ready_i),
        .r_beat_i     (r_beat_i),
        .r_last_i     (r_last_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .state_o      (state_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [55:0] exp_q[$];   // {addr, len} of expected AR handshakes
    int resp_q[$];           // beats still to return per issued burst
    int r_auto;
    int ar_cnt, rbeat_cnt, done_cnt;

    typedef struct {
        logic [AW-1:0]      base;
        logic [SW-1:0]      size;
        logic [7:0]         len;
        int                 n_ar;
        logic [3:0][AW-1:0] addr;
        logic [3:0][7:0]    alen;
        int                 beats;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: account for the handshakes about to happen, step the edge,
    // then drive the R responder for the next cycle.
    task automatic tick();
        logic [55:0] e;
        if (ar_valid_o === 1'b1 && ar_ready_i) begin
            ar_cnt++;
            resp_q.push_back(int'(ar_len_o) + 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ar: got addr 0x%0h len 0x%0h expected no AR", ar_addr_o, ar_len_o);
            end else begin
                e = exp_q.pop_front();
                check("ar_addr", 64'(ar_addr_o), 64'(e[55:8]));
                check("ar_len", 64'(ar_len_o), 64'(e[7:0]));
            end
        end
        if (r_beat_i && resp_q.size() > 0) begin
            rbeat_cnt++;
            resp_q[0] = resp_q[0] - 1;
            if (resp_q[0] == 0) void'(resp_q.pop_front());
        end
        if (frame_done_o === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
        if (r_auto != 0 && resp_q.size() > 0) begin
            r_beat_i = 1'b1;
            r_last_i = (resp_q[0] == 1);
        end else begin
            r_beat_i = 1'b0;
            r_last_i = 1'b0;
        end
    endtask

    task automatic r_stop();
        r_auto   = 0;
        r_beat_i = 1'b0;
        r_last_i = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (frame_done_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (frame_done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got no frame_done after %0d cycles, required a pulse", name, budget);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [7:0] l);
        exp_q.push_back({a, l});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{base: 48'h8000_0000, size: 32'h840, len: 8'hFF, n_ar: 2,
                    addr: {48'h0, 48'h0, 48'h8000_0800, 48'h8000_0000},
                    alen: {8'h0, 8'h0, 8'h07, 8'hFF}, beats: 264};
        vecs[1] = '{base: 48'h8000_0F80, size: 32'h100, len: 8'hFF, n_ar: 2,
                    addr: {48'h0, 48'h0, 48'h8000_1000, 48'h8000_0F80},
                    alen: {8'h0, 8'h0, 8'h0F, 8'h0F}, beats: 32};
        vecs[2] = '{base: 48'h1005, size: 32'h11, len: 8'h03, n_ar: 1,
                    addr: {48'h0, 48'h0, 48'h0, 48'h1000},
                    alen: {8'h0, 8'h0, 8'h0, 8'h02}, beats: 3};
        vecs[3] = '{base: 48'h2000, size: 32'h40, len: 8'h01, n_ar: 4,
                    addr: {48'h2030, 48'h2020, 48'h2010, 48'h2000},
                    alen: {8'h01, 8'h01, 8'h01, 8'h01}, beats: 8};
        vecs[4] = '{base: 48'h0FF8, size: 32'h18, len: 8'hFF, n_ar: 2,
                    addr: {48'h0, 48'h0, 48'h1000, 48'h0FF8},
                    alen: {8'h0, 8'h0, 8'h01, 8'h00}, beats: 3};

        rst_i = 1'b1; enable_i = 1'b0; frame_start_i = 1'b0; ar_ready_i = 1'b0;
        r_beat_i = 1'b0; r_last_i = 1'b0; frame_base_i = '0; frame_size_i = '0;
        burst_len_i = '0; fifo_free_i = '0; r_auto = 0;
        ar_cnt = 0; rbeat_cnt = 0; done_cnt = 0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("rst_ar_valid", 64'(ar_valid_o), 64'd0);
        check("rst_ar_addr", 64'(ar_addr_o), 64'd0);
        check("rst_ar_len", 64'(ar_len_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_frame_done", 64'(frame_done_o), 64'd0);

        // ---------------- table-driven whole frames ----------------
        enable_i = 1'b1; fifo_free_i = 9'd256; ar_ready_i = 1'b1; r_auto = 1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vecs[i].n_ar; k++) push_exp(vecs[i].addr[k], vecs[i].alen[k]);
            ar_cnt = 0; rbeat_cnt = 0; done_cnt = 0;
            frame_base_i = vecs[i].base;
            frame_size_i = vecs[i].size;
            burst_len_i  = vecs[i].len;
            pulse_start();
            check("lat_n1_valid", 64'(ar_valid_o), 64'd0);
            tick();
            check("lat_n2_valid", 64'(ar_valid_o), 64'd1);
            wait_done("vec_frame", 2000);
            check("vec_busy_at_done", 64'(busy_o), 64'd0);
            tick();
            check("vec_done_width", 64'(frame_done_o), 64'd0);
            check("vec_ar_count", 64'(ar_cnt), 64'(vecs[i].n_ar));
            check("vec_beats_returned", 64'(rbeat_cnt), 64'(vecs[i].beats));
            check("vec_done_count", 64'(done_cnt), 64'd1);
            check("vec_exp_left", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end

        // ---------------- credit, outstanding limit, enable drop ----------------
        for (int k = 0; k < 5; k++) push_exp(48'(k * 'h80), 8'h0F);
        ar_cnt = 0; done_cnt = 0;
        r_stop();
        fifo_free_i = 9'd10; frame_base_i = '0; frame_size_i = 32'h1000; burst_len_i = 8'h0F;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_credit_valid", 64'(ar_valid_o), 64'd0);
        end
        fifo_free_i = 9'd16;
        tick();
        check("credit_release_valid", 64'(ar_valid_o), 64'd1);
        tick();  // handshake of burst 0
        for (int k = 0; k < 4; k++) begin
            tick();
            check("reserved_blocks_valid", 64'(ar_valid_o), 64'd0);
        end
        fifo_free_i = 9'd256;
        for (int n = 0; n < 50 && ar_cnt < 4; n++) tick();
        check("outst_ar_count", 64'(ar_cnt), 64'd4);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("max_outst_valid", 64'(ar_valid_o), 64'd0);
        end
        ar_ready_i = 1'b0;
        r_auto = 1;
        for (int n = 0; n < 100 && resp_q.size() > 3; n++) tick();
        r_stop();
        check("one_burst_returned", 64'(resp_q.size()), 64'd3);
        tick();
        check("fifth_ar_valid", 64'(ar_valid_o), 64'd1);
        enable_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("held_valid", 64'(ar_valid_o), 64'd1);
            check("held_addr", 64'(ar_addr_o), 64'h200);
        end
        ar_ready_i = 1'b1;
        tick();
        check("fifth_ar_count", 64'(ar_cnt), 64'd5);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_ar_after_disable", 64'(ar_valid_o), 64'd0);
        end
        check("disable_busy_held", 64'(busy_o), 64'd1);
        r_auto = 1;
        wait_done("disable_drain", 500);
        check("disable_busy_at_done", 64'(busy_o), 64'd0);
        tick();
        check("disable_done_width", 64'(frame_done_o), 64'd0);
        check("disable_exp_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        enable_i = 1'b1;

        // ---------------- empty frame ----------------
        ar_cnt = 0;
        frame_size_i = '0;
        pulse_start();
        check("size0_valid", 64'(ar_valid_o), 64'd0);
        check("size0_done_early", 64'(frame_done_o), 64'd0);
        check("size0_busy", 64'(busy_o), 64'd1);
        tick();
        check("size0_done", 64'(frame_done_o), 64'd1);
        check("size0_busy_after", 64'(busy_o), 64'd0);
        tick();
        check("size0_done_width", 64'(frame_done_o), 64'd0);
        check("size0_ar_count", 64'(ar_cnt), 64'd0);

        // ---------------- frame_start and cfg changes while issuing ----------------
        ar_cnt = 0; done_cnt = 0;
        push_exp(48'h8000_0F80, 8'h0F);
        push_exp(48'h8000_1000, 8'h0F);
        frame_base_i = 48'h8000_0F80; frame_size_i = 32'h100; burst_len_i = 8'hFF;
        pulse_start();
        tick();
        tick();
        frame_base_i = 48'h4000; frame_size_i = 32'h800; burst_len_i = 8'h00;
        pulse_start();
        wait_done("restart_frame", 500);
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("no_requeue_valid", 64'(ar_valid_o), 64'd0);
        end
        check("restart_ar_count", 64'(ar_cnt), 64'd2);
        check("restart_done_count", 64'(done_cnt), 64'd1);
        check("restart_busy", 64'(busy_o), 64'd0);
        exp_q.delete();

        // ---------------- reset mid-frame ----------------
        ar_cnt = 0;
        r_stop();
        push_exp(48'h8000_0000, 8'hFF);
        frame_base_i = 48'h8000_0000; frame_size_i = 32'h840; burst_len_i = 8'hFF;
        pulse_start();
        for (int n = 0; n < 10 && ar_cnt < 1; n++) tick();
        check("midrst_ar_count", 64'(ar_cnt), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        resp_q.delete();
        check("midrst_valid", 64'(ar_valid_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_addr", 64'(ar_addr_o), 64'd0);
        check("midrst_len", 64'(ar_len_o), 64'd0);
        tick();
        check("midrst_idle_valid", 64'(ar_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
